// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stall with configurable length, data-memory
// freeze, branch flush arbitration and a saturating stall-cycle counter.
module hazard_ctrl_unit #(
  parameter int REG_ADDR_WIDTH    = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      if_id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] if_id_rs1,
  input  logic                      if_id_rs1_used,
  input  logic [REG_ADDR_WIDTH-1:0] if_id_rs2,
  input  logic                      if_id_rs2_used,
  input  logic                      id_ex_valid,
  input  logic                      id_ex_mem_rd_en,
  input  logic [REG_ADDR_WIDTH-1:0] id_ex_rd,
  input  logic                      branch_taken,
  input  logic                      dmem_req,
  input  logic                      dmem_ready,
  output logic                      pc_write,
  output logic                      if_id_write,
  output logic                      if_id_flush,
  output logic                      id_ex_bubble,
  output logic                      pipe_hold,
  output logic                      stall_active,
  output logic [CNT_WIDTH-1:0]      stall_count,
  output logic                      dbg_state
);

  typedef enum logic {RUN = 1'b0, LU_STALL = 1'b1} state_e;

  state_e         state_q, state_d;
  logic [2:0]     lu_cnt_q, lu_cnt_d;
  logic [CNT_WIDTH-1:0] stall_count_q;
  logic           lu_hit;
  logic           mem_wait;

  // Data memory handshake: an access completes on a cycle where dmem_req and
  // dmem_ready are both high; dmem_req high with dmem_ready low is a wait state.
  assign mem_wait = dmem_req & ~dmem_ready;

  assign lu_hit = id_ex_valid & id_ex_mem_rd_en & (id_ex_rd != '0) & if_id_valid &
                  ((if_id_rs1_used & (if_id_rs1 == id_ex_rd)) |
                   (if_id_rs2_used & (if_id_rs2 == id_ex_rd)));

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_hold    = 1'b0;
    state_d      = state_q;
    lu_cnt_d     = lu_cnt_q;
    if (!rst_n) begin
      state_d  = RUN;
      lu_cnt_d = 3'd0;
    end else if (mem_wait) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_hold   = 1'b1;
    end else if (branch_taken) begin
      // The stalled consumer is squashed, so any owed bubbles are dropped.
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      state_d      = RUN;
      lu_cnt_d     = 3'd0;
    end else if (state_q == LU_STALL) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      lu_cnt_d     = lu_cnt_q - 3'd1;
      if (lu_cnt_q == 3'd1) state_d = RUN;
    end else if (lu_hit) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if (LOAD_STALL_CYCLES > 1) begin
        state_d  = LU_STALL;
        lu_cnt_d = 3'(LOAD_STALL_CYCLES - 1);
      end
    end
  end

  assign stall_active = ~pc_write;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= RUN;
      lu_cnt_q      <= 3'd0;
      stall_count_q <= '0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
      if (stall_active && (stall_count_q != '1)) stall_count_q <= stall_count_q + 1'b1;
    end
  end

  assign stall_count = stall_count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: three instances (1-cycle, 3-cycle, 3-cycle with 4-bit counter)
// share one directed stimulus stream and are checked against a bubbles-owed model.
module tb_hazard_ctrl_unit;
  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       if_id_valid, if_id_rs1_used, if_id_rs2_used;
  logic [4:0] if_id_rs1, if_id_rs2, id_ex_rd;
  logic       id_ex_valid, id_ex_mem_rd_en, branch_taken, dmem_req, dmem_ready;

  logic [N-1:0] pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, stall_active, dbg_state;
  logic [15:0]  cnt_ext [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int LSC = (g == 0) ? 1 : 3;
    localparam int CW  = (g == 2) ? 4 : 16;
    logic [CW-1:0] cnt;
    hazard_ctrl_unit #(.REG_ADDR_WIDTH(5), .LOAD_STALL_CYCLES(LSC), .CNT_WIDTH(CW)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .if_id_valid(if_id_valid), .if_id_rs1(if_id_rs1), .if_id_rs1_used(if_id_rs1_used),
      .if_id_rs2(if_id_rs2), .if_id_rs2_used(if_id_rs2_used),
      .id_ex_valid(id_ex_valid), .id_ex_mem_rd_en(id_ex_mem_rd_en), .id_ex_rd(id_ex_rd),
      .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .pc_write(pc_write[g]), .if_id_write(if_id_write[g]), .if_id_flush(if_id_flush[g]),
      .id_ex_bubble(id_ex_bubble[g]), .pipe_hold(pipe_hold[g]), .stall_active(stall_active[g]),
      .stall_count(cnt), .dbg_state(dbg_state[g])
    );
    assign cnt_ext[g] = 16'(cnt);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h at %0t", name, idx, act, exp, $time);
    end
  endtask

  // Model: bubbles still owed to the current hazard, and the saturating stall count.
  int lsc_tab  [N] = '{1, 3, 3};
  int cmax_tab [N] = '{65535, 65535, 15};
  int m_owed   [N] = '{0, 0, 0};
  int m_cnt    [N] = '{0, 0, 0};
  int bub_tot  [N] = '{0, 0, 0};
  int hold_tot [N] = '{0, 0, 0};
  int fl_tot   [N] = '{0, 0, 0};

  always @(negedge clk) begin : p_cmp
    logic [5:0] exp_o, act_o;
    logic       hit, mw;
    int         nxt;
    hit = id_ex_valid && id_ex_mem_rd_en && (id_ex_rd != 0) && if_id_valid &&
          ((if_id_rs1_used && if_id_rs1 == id_ex_rd) || (if_id_rs2_used && if_id_rs2 == id_ex_rd));
    mw  = dmem_req && !dmem_ready;
    for (int g = 0; g < N; g++) begin
      check("stall_count", g, 32'(cnt_ext[g]), m_cnt[g]);
      check("dbg_state", g, 32'(dbg_state[g]), (m_owed[g] > 0) ? 1 : 0);
      nxt = m_owed[g];
      // {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, stall_active}
      if (!rst_n)            exp_o = 6'b110000;
      else if (mw)           exp_o = 6'b000011;
      else if (branch_taken) begin exp_o = 6'b111100; nxt = 0; end
      else if (m_owed[g] > 0) begin exp_o = 6'b000101; nxt = m_owed[g] - 1; end
      else if (hit)          begin exp_o = 6'b000101; nxt = lsc_tab[g] - 1; end
      else                   exp_o = 6'b110000;
      act_o = {pc_write[g], if_id_write[g], if_id_flush[g], id_ex_bubble[g], pipe_hold[g], stall_active[g]};
      check("outputs", g, 32'(act_o), 32'(exp_o));
      bub_tot[g]  += int'(id_ex_bubble[g]);
      hold_tot[g] += int'(pipe_hold[g]);
      fl_tot[g]   += int'(if_id_flush[g]);
      if (!rst_n) begin
        m_owed[g] = 0;
        m_cnt[g]  = 0;
      end else begin
        m_owed[g] = nxt;
        if (exp_o[0] && m_cnt[g] < cmax_tab[g]) m_cnt[g] = m_cnt[g] + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_quiet();
    if_id_valid = 1'b1; if_id_rs1 = 5'd1; if_id_rs1_used = 1'b1; if_id_rs2 = 5'd2; if_id_rs2_used = 1'b1;
    id_ex_valid = 1'b1; id_ex_mem_rd_en = 1'b0; id_ex_rd = 5'd3;
    branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic set_load(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd);
    set_quiet();
    if_id_rs1 = rs1; if_id_rs1_used = u1; if_id_rs2 = rs2; if_id_rs2_used = u2;
    id_ex_mem_rd_en = 1'b1; id_ex_rd = rd;
  endtask

  task automatic do_reset();
    set_quiet();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  int b0 [N];
  int h0 [N];
  int f0 [N];

  task automatic mark();
    for (int g = 0; g < N; g++) begin b0[g] = bub_tot[g]; h0[g] = hold_tot[g]; f0[g] = fl_tot[g]; end
  endtask

  task automatic expect_lit(input string tag, input int c0, input int c1, input int c2,
                            input int bb0, input int bb1, input int bb2);
    int ce [N];
    int be [N];
    ce = '{c0, c1, c2};
    be = '{bb0, bb1, bb2};
    for (int g = 0; g < N; g++) begin
      check({tag, "_count"}, g, 32'(cnt_ext[g]), ce[g]);
      check({tag, "_bubbles"}, g, bub_tot[g] - b0[g], be[g]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    set_quiet();
    rst_n = 1'b0;
    do_reset();
    check("reset_count", 0, 32'(cnt_ext[0]), 0);
    check("reset_pc_write", 0, 32'(pc_write), 32'b111);

    // rs1 load-use hazard
    mark(); set_load(5'd5, 1'b1, 5'd0, 1'b0, 5'd5); tick();
    set_quiet(); repeat (4) tick();
    expect_lit("rs1_hazard", 1, 3, 3, 1, 3, 3);

    // rs2 load-use hazard
    do_reset(); mark(); set_load(5'd4, 1'b1, 5'd7, 1'b1, 5'd7); tick();
    set_quiet(); repeat (4) tick();
    expect_lit("rs2_hazard", 1, 3, 3, 1, 3, 3);

    // Non-hazards: x0, store, invalid ID/EX, invalid IF/ID, unused operand
    do_reset(); mark();
    set_load(5'd0, 1'b1, 5'd0, 1'b1, 5'd0); tick();
    set_load(5'd5, 1'b1, 5'd0, 1'b0, 5'd5); id_ex_mem_rd_en = 1'b0; tick();
    set_load(5'd5, 1'b1, 5'd0, 1'b0, 5'd5); id_ex_valid = 1'b0; tick();
    set_load(5'd5, 1'b1, 5'd0, 1'b0, 5'd5); if_id_valid = 1'b0; tick();
    set_load(5'd5, 1'b0, 5'd0, 1'b1, 5'd5); tick();
    set_quiet(); repeat (2) tick();
    expect_lit("no_hazard", 0, 0, 0, 0, 0, 0);

    // Memory wait-state freeze during the second bubble
    do_reset(); mark(); set_load(5'd5, 1'b1, 5'd0, 1'b0, 5'd5); tick();
    set_quiet(); dmem_req = 1'b1; dmem_ready = 1'b0; repeat (2) tick();
    set_quiet(); repeat (4) tick();
    expect_lit("mem_wait", 3, 5, 5, 1, 3, 3);
    check("mem_wait_hold", 1, hold_tot[1] - h0[1], 2);

    // Branch in the second stall cycle cancels remaining bubbles
    do_reset(); mark(); set_load(5'd5, 1'b1, 5'd0, 1'b0, 5'd5); tick();
    set_quiet(); branch_taken = 1'b1; tick();
    set_quiet(); repeat (4) tick();
    expect_lit("branch_cancel", 1, 1, 1, 2, 2, 2);
    check("branch_flush", 1, fl_tot[1] - f0[1], 1);
    check("branch_state", 1, 32'(dbg_state[1]), 0);

    // Branch and memory wait together: freeze first, then flush
    do_reset(); mark();
    set_quiet(); branch_taken = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0; repeat (2) tick();
    set_quiet(); branch_taken = 1'b1; tick();
    set_quiet(); repeat (2) tick();
    expect_lit("branch_memwait", 2, 2, 2, 1, 1, 1);
    check("branch_memwait_flush", 0, fl_tot[0] - f0[0], 1);
    check("branch_memwait_hold", 0, hold_tot[0] - h0[0], 2);

    // Counter saturation, then reset in the middle of a stall
    do_reset();
    set_quiet(); dmem_req = 1'b1; dmem_ready = 1'b0; repeat (20) tick();
    set_quiet(); tick();
    check("sat_count", 0, 32'(cnt_ext[0]), 20);
    check("sat_count", 2, 32'(cnt_ext[2]), 15);
    set_load(5'd5, 1'b1, 5'd0, 1'b0, 5'd5); tick();
    check("sat_hold", 2, 32'(cnt_ext[2]), 15);
    check("stall_state", 1, 32'(dbg_state[1]), 1);
    set_quiet(); rst_n = 1'b0; #1;
    check("rst_pc_write", 0, 32'(pc_write), 32'b111);
    check("rst_bubble", 0, 32'(id_ex_bubble), 32'b000);
    tick();
    check("rst_count", 1, 32'(cnt_ext[1]), 0);
    check("rst_state", 1, 32'(dbg_state[1]), 0);
    rst_n = 1'b1; mark(); repeat (4) tick();
    expect_lit("post_reset", 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
